alu_cmd_sched: RTL and testbench
================================

Name: alu_cmd_sched

Overview:
- Two-requester scheduler for the shared 64-bit command ALU.
- Command set: RST=0, INIT=1, ADD=2, SUB=3, MULT=4, DIV=5, REM=6, HLT=7.
- Arbitrates requests round-robin and issues one command at a time on the ALU rdy/cmd/opd interface.
- Waits for the matching done/done_cmd completion, routes it back to the owning requester, and polices halt, mismatch and timeout conditions.

Parameters:
- DW, 64, operand width.
- TMO, 32, max cycles in WAIT before timeout; legal range 2..255.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- req_valid  in  2  per-requester request valid; bit n = requester n.
- req_ready  out  2  per-requester accept; combinational.
- req0_cmd  in  3  requester 0 command.
- req1_cmd  in  3  requester 1 command.
- req0_opd1, req0_opd2  in  DW  requester 0 operands.
- req1_opd1, req1_opd2  in  DW  requester 1 operands.
- rdy_o  out  1  issue strobe to ALU.
- cmd_o  out  3  issued command.
- opd1_o, opd2_o  out  DW  issued operands.
- done_i  in  1  ALU completion strobe.
- done_cmd_i  in  3  command the ALU reports as complete.
- resp_valid  out  2  one-cycle completion pulse to owner.
- resp_cmd  out  3  completed command.
- resp_err  out  1  qualifies resp_valid: completion was a timeout.
- err_o  out  2  sticky errors: bit0 = done_cmd mismatch, bit1 = timeout.
- err_clr  in  1  synchronous clear of err_o.
- halted_o  out  1  scheduler in HALTED.
- busy_o  out  1  state is ISSUE or WAIT.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer favours req0. All registered outputs are 0: rdy_o, cmd_o, opd1_o, opd2_o, resp_valid, resp_cmd, resp_err, err_o, halted_o, busy_o.
- Reset mid-WAIT discards the in-flight command. No resp is generated.
- States: IDLE, ISSUE, WAIT, HALTED.
- IDLE arbitration:
  - Winner = the only valid requester.
  - If both valid, winner = the one not granted last.
  - req_ready[winner]=1 combinationally; req_ready of the loser is 0.
  - In any other state req_ready=0.
- Accept at posedge with valid&ready: capture cmd, operands and owner; flip rr pointer to favour the other requester; next state ISSUE.
- ISSUE, exactly 1 cycle:
  - rdy_o=1; cmd_o/opd1_o/opd2_o = captured values.
  - Next state WAIT; timer cleared to 0.
  - cmd_o/opd outputs hold until the next issue. rdy_o is 0 outside ISSUE.
- WAIT, timer increments every cycle:
  - done_i=1 and done_cmd_i==captured cmd: resp_valid[owner]=1 for 1 cycle, resp_cmd=done_cmd_i, resp_err=0. Next state HALTED if cmd==HLT, else IDLE.
  - done_i=1 with mismatched done_cmd_i: err_o[0] set; stay in WAIT; timer not reset.
  - Timer reaches TMO-1 with no matching done: err_o[1] set; resp_valid[owner]=1, resp_cmd=captured cmd, resp_err=1; next state IDLE.
  - A matching done in the same cycle as timeout takes priority; no error is flagged.
- HALTED:
  - halted_o=1.
  - Only requests with cmd==RST are eligible for arbitration. Non-RST requests see req_ready=0 and are not lost; they wait.
  - Accepted RST goes through ISSUE/WAIT. Its completion returns to IDLE and halted_o drops.
  - If that RST times out, the state returns to HALTED, not IDLE.
- Latency: accept at edge k, rdy_o high in cycle k+1, earliest done sampled at edge k+2. resp_valid asserts the cycle after done is sampled. Minimum request-to-response is 3 cycles.
- err_o bits are sticky until err_clr=1. If set and clear coincide, set wins.
- resp outputs are registered. resp_cmd holds its value between pulses.
- Throughput: one command in flight. A new accept is possible in the IDLE cycle after resp.

Test Plan:
- Single ADD: req0 ADD, opd1=5, opd2=7 -> rdy_o pulse, cmd_o=2, opd1_o=5, opd2_o=7 one cycle after accept. done_i with done_cmd_i=2 two cycles later -> resp_valid=01, resp_cmd=2, err_o=00.
- Fairness: both requesters hold valid (req0 SUB, req1 MULT), ALU returns done 1 cycle after each rdy_o -> grants alternate req0, req1, req0, req1. resp_valid alternates 01/10.
- Mismatch then match: issue DIV; done_cmd_i=ADD first -> err_o=01, still WAIT. Then done_cmd_i=DIV -> resp_valid pulse, resp_cmd=5.
- Timeout (TMO=32): issue REM, no done -> resp_err=1 and err_o=10 exactly 32 cycles after rdy_o. err_clr -> err_o=00.
- Halt: req0 HLT completes -> halted_o=1. req1 INIT held with req_ready=0 for 20 cycles. req0 RST issued and completed -> halted_o=0, then INIT accepted.
- Async reset: drop rst mid-WAIT of MULT -> all outputs 0 immediately, no resp. After release the next ADD from req1 completes normally.

Source files
------------

// File: rtl/alu_cmd_sched.sv
// alu_cmd_sched: round-robin two-requester scheduler for the shared 64-bit command ALU.
// Rev 1.0 - initial release.
`default_nettype none

module alu_cmd_sched #(
  parameter int DW  = 64,
  parameter int TMO = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [2:0]    req0_cmd,
  input  logic [2:0]    req1_cmd,
  input  logic [DW-1:0] req0_opd1,
  input  logic [DW-1:0] req0_opd2,
  input  logic [DW-1:0] req1_opd1,
  input  logic [DW-1:0] req1_opd2,
  output logic          rdy_o,
  output logic [2:0]    cmd_o,
  output logic [DW-1:0] opd1_o,
  output logic [DW-1:0] opd2_o,
  input  logic          done_i,
  input  logic [2:0]    done_cmd_i,
  output logic [1:0]    resp_valid,
  output logic [2:0]    resp_cmd,
  output logic          resp_err,
  output logic [1:0]    err_o,
  input  logic          err_clr,
  output logic          halted_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [2:0] CMD_RST  = 3'd0;
  localparam logic [2:0] CMD_HLT  = 3'd7;
  // Timer starts at 0 in the first WAIT cycle; it reaches TMO-1 on the edge where it equals TMO-2.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 2);

  state_t      state, state_nxt;
  logic        rr;          // requester favoured when both are eligible
  logic        own;         // owner of the in-flight command
  logic        from_halt;   // in-flight command was accepted while HALTED
  logic [7:0]  timer;
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        accept;
  logic        win;
  logic        match;
  logic        mism;
  logic        tmo;

  always_comb begin
    elig      = 2'b00;
    grant     = 2'b00;
    match     = 1'b0;
    mism      = 1'b0;
    tmo       = 1'b0;
    state_nxt = state;

    elig[0] = req_valid[0] & ((state == S_IDLE) | ((state == S_HALTED) & (req0_cmd == CMD_RST)));
    elig[1] = req_valid[1] & ((state == S_IDLE) | ((state == S_HALTED) & (req1_cmd == CMD_RST)));
    if (elig == 2'b11) begin
      grant = rr ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end

    if (state == S_WAIT) begin
      match = done_i & (done_cmd_i == cmd_o);
      mism  = done_i & (done_cmd_i != cmd_o);
      tmo   = (timer == TMO_LAST) & ~match;
    end

    case (state)
      S_IDLE:   if (|grant) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (match) begin
          state_nxt = (cmd_o == CMD_HLT) ? S_HALTED : S_IDLE;
        end else if (tmo) begin
          state_nxt = from_halt ? S_HALTED : S_IDLE;
        end
      end
      S_HALTED: if (|grant) state_nxt = S_ISSUE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign win       = grant[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr         <= 1'b0;
      own        <= 1'b0;
      from_halt  <= 1'b0;
      timer      <= 8'd0;
      rdy_o      <= 1'b0;
      cmd_o      <= 3'd0;
      opd1_o     <= '0;
      opd2_o     <= '0;
      resp_valid <= 2'b00;
      resp_cmd   <= 3'd0;
      resp_err   <= 1'b0;
      err_o      <= 2'b00;
      halted_o   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      rdy_o <= accept;
      if (accept) begin
        cmd_o     <= win ? req1_cmd  : req0_cmd;
        opd1_o    <= win ? req1_opd1 : req0_opd1;
        opd2_o    <= win ? req1_opd2 : req0_opd2;
        own       <= win;
        rr        <= ~win;
        from_halt <= (state == S_HALTED);
      end

      if (state == S_ISSUE) begin
        timer <= 8'd0;
      end else if (state == S_WAIT) begin
        timer <= timer + 8'd1;
      end

      resp_valid <= (match | tmo) ? (own ? 2'b10 : 2'b01) : 2'b00;
      if (match | tmo) begin
        resp_cmd <= match ? done_cmd_i : cmd_o;
      end
      resp_err <= tmo;

      // A new error in the same cycle as err_clr survives the clear.
      err_o    <= (err_o & ~{2{err_clr}}) | {tmo, mism};
      halted_o <= (state_nxt == S_HALTED);
      busy_o   <= (state_nxt == S_ISSUE) | (state_nxt == S_WAIT);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sched.sv
// tb_alu_cmd_sched: directed and randomized checks of alu_cmd_sched against a transaction-level model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_alu_cmd_sched;
  localparam int DW  = 64;
  localparam int TMO = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2:0]    req0_cmd, req1_cmd;
  logic [DW-1:0] req0_opd1, req0_opd2, req1_opd1, req1_opd2;
  logic          rdy_o;
  logic [2:0]    cmd_o;
  logic [DW-1:0] opd1_o, opd2_o;
  logic          done_i;
  logic [2:0]    done_cmd_i;
  logic [1:0]    resp_valid;
  logic [2:0]    resp_cmd;
  logic          resp_err;
  logic [1:0]    err_o;
  logic          err_clr;
  logic          halted_o;
  logic          busy_o;

  int n_chk  = 0;
  int n_fail = 0;
  int pref   = 0;      // model: requester favoured on a tie
  bit halted_m = 1'b0; // model: scheduler is halted
  bit clr_with_mism = 1'b0;

  alu_cmd_sched #(.DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .req0_opd1(req0_opd1), .req0_opd2(req0_opd2),
    .req1_opd1(req1_opd1), .req1_opd2(req1_opd2),
    .rdy_o(rdy_o), .cmd_o(cmd_o), .opd1_o(opd1_o), .opd2_o(opd2_o),
    .done_i(done_i), .done_cmd_i(done_cmd_i),
    .resp_valid(resp_valid), .resp_cmd(resp_cmd), .resp_err(resp_err),
    .err_o(err_o), .err_clr(err_clr),
    .halted_o(halted_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_err;
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("err_clear", err_o, 2'b00);
  endtask

  // One full transaction: present requests, predict the winner, drive the ALU side, check the response.
  task automatic run_cmd(input logic [1:0] v, input logic [2:0] c0, input logic [2:0] c1,
                         input logic [63:0] a0, input logic [63:0] b0,
                         input logic [63:0] a1, input logic [63:0] b1,
                         input int delay, input bit mism, input bit tmo, input bit hold);
    logic [1:0]  elig;
    logic [1:0]  onehot;
    logic [2:0]  c;
    logic [63:0] a, b;
    int          win;
    int          cnt;
    req_valid = v;
    req0_cmd = c0; req1_cmd = c1;
    req0_opd1 = a0; req0_opd2 = b0; req1_opd1 = a1; req1_opd2 = b1;
    #1;
    elig = halted_m ? (v & {c1 == 3'd0, c0 == 3'd0}) : v;
    if (elig == 2'b11) win = pref;
    else win = elig[1] ? 1 : 0;
    onehot = (win == 1) ? 2'b10 : 2'b01;
    c = (win == 1) ? c1 : c0;
    a = (win == 1) ? a1 : a0;
    b = (win == 1) ? b1 : b0;
    chk("req_ready", req_ready, onehot);
    step;
    pref = 1 - win;
    if (!hold) req_valid = 2'b00;
    chk("issue_rdy", rdy_o, 1'b1);
    chk("issue_cmd", cmd_o, c);
    chk("issue_opd1", opd1_o, a);
    chk("issue_opd2", opd2_o, b);
    chk("issue_busy", busy_o, 1'b1);
    step;
    chk("rdy_drop", rdy_o, 1'b0);
    if (tmo) begin
      cnt = 1;
      while (resp_valid === 2'b00 && cnt < 100) begin
        step;
        cnt++;
      end
      chk("tmo_latency", cnt, TMO);
      chk("tmo_resp_valid", resp_valid, onehot);
      chk("tmo_resp_err", resp_err, 1'b1);
      chk("tmo_resp_cmd", resp_cmd, c);
      chk("tmo_err_bit", err_o[1], 1'b1);
    end else begin
      repeat (delay) step;
      if (mism) begin
        done_i = 1'b1;
        done_cmd_i = c ^ 3'd1;
        err_clr = clr_with_mism;
        step;
        done_i = 1'b0;
        err_clr = 1'b0;
        chk("mism_err_bit", err_o[0], 1'b1);
        chk("mism_no_resp", resp_valid, 2'b00);
        chk("mism_busy", busy_o, 1'b1);
      end
      done_i = 1'b1;
      done_cmd_i = c;
      step;
      done_i = 1'b0;
      chk("resp_valid", resp_valid, onehot);
      chk("resp_cmd", resp_cmd, c);
      chk("resp_err", resp_err, 1'b0);
      halted_m = (c == 3'd7);
    end
    chk("halted", halted_o, halted_m);
    chk("busy_end", busy_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rv;
    rst = 1'b0; req_valid = 2'b00; req0_cmd = 3'd0; req1_cmd = 3'd0;
    req0_opd1 = '0; req0_opd2 = '0; req1_opd1 = '0; req1_opd2 = '0;
    done_i = 1'b0; done_cmd_i = 3'd0; err_clr = 1'b0;
    step;
    chk("rst_rdy", rdy_o, 1'b0);
    chk("rst_cmd", cmd_o, 3'd0);
    chk("rst_opd1", opd1_o, 64'd0);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_err", err_o, 2'b00);
    chk("rst_halted", halted_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    rst = 1'b1;
    step;

    // Single ADD from req0
    run_cmd(2'b01, 3'd2, 3'd0, 64'd5, 64'd7, 64'd0, 64'd0, 0, 1'b0, 1'b0, 1'b0);
    chk("add_err", err_o, 2'b00);
    step;
    chk("resp_pulse_drop", resp_valid, 2'b00);
    chk("resp_cmd_hold", resp_cmd, 3'd2);

    // Fairness with both requesters holding valid
    for (int i = 0; i < 4; i++) begin
      run_cmd(2'b11, 3'd3, 3'd4, 64'd10 + 64'(i), 64'd20, 64'd30 + 64'(i), 64'd40, 0, 1'b0, 1'b0, 1'b1);
    end
    req_valid = 2'b00;

    // Mismatch then match, with err_clr coinciding with the set
    clr_with_mism = 1'b1;
    run_cmd(2'b01, 3'd5, 3'd0, 64'd100, 64'd3, 64'd0, 64'd0, 1, 1'b1, 1'b0, 1'b0);
    clr_with_mism = 1'b0;
    chk("div_err", err_o, 2'b01);
    clear_err;

    // Timeout on REM
    run_cmd(2'b01, 3'd6, 3'd0, 64'd9, 64'd4, 64'd0, 64'd0, 0, 1'b0, 1'b1, 1'b0);
    chk("rem_err", err_o, 2'b10);
    clear_err;

    // Halt, blocked INIT, RST timeout stays halted, RST completes, INIT proceeds
    run_cmd(2'b01, 3'd7, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 1'b0, 1'b0, 1'b0);
    req_valid = 2'b10; req1_cmd = 3'd1;
    for (int i = 0; i < 20; i++) begin
      step;
      chk("halt_block_ready", req_ready, 2'b00);
    end
    run_cmd(2'b11, 3'd0, 3'd1, 64'd0, 64'd0, 64'd1, 64'd2, 0, 1'b0, 1'b1, 1'b0);
    clear_err;
    run_cmd(2'b11, 3'd0, 3'd1, 64'd0, 64'd0, 64'd1, 64'd2, 2, 1'b0, 1'b0, 1'b1);
    run_cmd(2'b10, 3'd0, 3'd1, 64'd0, 64'd0, 64'd1, 64'd2, 0, 1'b0, 1'b0, 1'b0);

    // Async reset in the middle of a MULT
    req_valid = 2'b01; req0_cmd = 3'd4; req0_opd1 = 64'd6; req0_opd2 = 64'd8;
    step;
    req_valid = 2'b00;
    step;
    step;
    #1 rst = 1'b0;
    #1;
    chk("arst_cmd", cmd_o, 3'd0);
    chk("arst_opd1", opd1_o, 64'd0);
    chk("arst_opd2", opd2_o, 64'd0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_resp_cmd", resp_cmd, 3'd0);
    pref = 0;
    halted_m = 1'b0;
    step;
    rst = 1'b1;
    done_i = 1'b1; done_cmd_i = 3'd4;
    step;
    done_i = 1'b0;
    step;
    chk("arst_no_resp", resp_valid, 2'b00);
    run_cmd(2'b10, 3'd0, 3'd2, 64'd0, 64'd0, 64'd11, 64'd22, 0, 1'b0, 1'b0, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      bit m, t;
      rv = 2'($urandom_range(1, 3));
      m = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 9) == 0);
      run_cmd(rv, 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)),
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 4), m, t, 1'b0);
      if (m || t) clear_err;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
